// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: shared FSM state encoding and default widths for the RAM arbiter
package ram_ctrl_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 1;
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_e;
endpackage

// File: rtl/rr_sel_2.sv
// rr_sel_2: two-way round-robin selector returning a one-hot grant
module rr_sel_2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);
  // on a tie the requester not served last wins
  always_comb gnt_o = (req_i == 2'b11) ? (last_i ? 2'b01 : 2'b10) : req_i;
endmodule

// File: rtl/ram_arbiter_2x8.sv
// ram_arbiter_2x8: two-requester round-robin arbiter in front of a single-port RAM
module ram_arbiter_2x8 #(
  parameter int DATA_W = ram_ctrl_pkg::DATA_W,
  parameter int ADDR_W = ram_ctrl_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              mem_r_w,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);
  import ram_ctrl_pkg::*;
  state_e            state_q;
  logic              sel_q, prio_q, mem_r_w_q;
  logic [1:0]        gnt, ack_q;
  logic [DATA_W-1:0] rdata_q, mem_data_in_q;
  logic [ADDR_W-1:0] mem_address_q;
  // prio_q names the favoured requester, so the last served one is its complement
  rr_sel_2 u_sel (.req_i(req), .last_i(~prio_q), .gnt_o(gnt));
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q       <= IDLE;
      sel_q         <= 1'b0;
      prio_q        <= 1'b0;
      ack_q         <= 2'b00;
      rdata_q       <= '0;
      mem_address_q <= '0;
      mem_data_in_q <= '0;
      mem_r_w_q     <= 1'b0;
    end else begin
      ack_q <= 2'b00;
      case (state_q)
        IDLE: if (|req) begin
          sel_q         <= gnt[1];
          mem_r_w_q     <= we[gnt[1]];
          mem_address_q <= gnt[1] ? addr1 : addr0;
          mem_data_in_q <= gnt[1] ? wdata1 : wdata0;
          state_q       <= ACCESS;
        end
        ACCESS: begin
          mem_r_w_q <= 1'b0;
          ack_q     <= mem_r_w_q ? {sel_q, ~sel_q} : 2'b00;
          state_q   <= mem_r_w_q ? DONE : WAIT;
        end
        WAIT: begin
          rdata_q <= mem_data_out;
          ack_q   <= {sel_q, ~sel_q};
          state_q <= DONE;
        end
        DONE: begin
          prio_q  <= ~sel_q;
          state_q <= IDLE;
        end
      endcase
    end
  assign ack         = ack_q;
  assign rdata       = rdata_q;
  assign busy        = state_q != IDLE;
  assign mem_r_w     = mem_r_w_q;
  assign mem_address = mem_address_q;
  assign mem_data_in = mem_data_in_q;
endmodule

// File: tb/tb_ram_arbiter_2x8.sv
// tb_ram_arbiter_2x8: transaction-level model check plus directed scenarios for ram_arbiter_2x8
module tb_ram_arbiter_2x8;
  localparam int DW = 8;
  localparam int AW = 1;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] req = 2'b00, we = 2'b00;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic [1:0] ack;
  logic [DW-1:0] rdata, mem_data_in, mem_data_out;
  logic busy, mem_r_w;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] ram [2] = '{8'h00, 8'h00};
  int n_pass = 0, n_total = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  ram_arbiter_2x8 dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .ack(ack), .rdata(rdata), .busy(busy),
    .mem_r_w(mem_r_w), .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out)
  );

  assign mem_data_out = ram[mem_address];
  always @(posedge clk) if (mem_r_w) ram[mem_address] <= mem_data_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Transaction model: k counts cycles since the sampling edge (0 = idle);
  // a write acks at k=2, a read at k=3, then one idle cycle follows.
  int k = 0;
  bit srv = 1'b0, m_we = 1'b0, fav = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wd = '0, exp_rdata = '0;
  logic [DW-1:0] ref_mem [2] = '{8'h00, 8'h00};

  always @(posedge clk or negedge rst)
    if (!rst) begin
      k = 0;
      fav = 1'b0;
      exp_rdata = '0;
    end else if (k == 0) begin
      if (req != 2'b00) begin
        srv = (req == 2'b11) ? fav : req[1];
        m_we = we[srv];
        m_addr = srv ? addr1 : addr0;
        m_wd = srv ? wdata1 : wdata0;
        k = 1;
      end
    end else if (k == (m_we ? 2 : 3)) begin
      fav = !srv;
      k = 0;
    end else begin
      if (k == 1 && m_we) ref_mem[m_addr] = m_wd;
      if (k == 2 && !m_we) exp_rdata = ref_mem[m_addr];
      k++;
    end

  always @(negedge clk) if (chk_en) begin
    if (!rst) begin
      chk("rst_ack", ack, 0);
      chk("rst_busy", busy, 0);
      chk("rst_wr", mem_r_w, 0);
      chk("rst_addr", mem_address, 0);
      chk("rst_wdata", mem_data_in, 0);
      chk("rst_rdata", rdata, 0);
    end else begin
      chk("m_busy", busy, k != 0);
      chk("m_ack", ack, (k == (m_we ? 2 : 3)) ? (srv ? 2'b10 : 2'b01) : 2'b00);
      chk("m_wr", mem_r_w, k == 1 && m_we);
      chk("m_rdata", rdata, exp_rdata);
      if (k != 0) begin
        chk("m_addr", mem_address, m_addr);
        chk("m_wdata", mem_data_in, m_wd);
      end
    end
  end

  int wr_cnt = 0, idle_cnt = 0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  always @(negedge clk) begin
    if (mem_r_w) begin
      wr_cnt++;
      wr_addr = mem_address;
      wr_data = mem_data_in;
    end
    if (rst && !busy) idle_cnt++;
  end

  task automatic run_ack(output logic [1:0] a, output int n);
    n = 0;
    a = 2'b00;
    while (a == 2'b00 && n < 20) begin
      @(posedge clk); #1;
      n++;
      a = ack;
    end
    chk("ack_seen", a != 2'b00, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    req = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    logic [1:0] a;
    int n, w0, prev;
    #3 rst = 1'b0;
    chk_en = 1'b1;
    #1;
    chk("init_ack", ack, 0);
    chk("init_busy", busy, 0);
    chk("init_rdata", rdata, 0);
    chk("init_wr", mem_r_w, 0);
    chk("init_addr", mem_address, 0);
    chk("init_wdata", mem_data_in, 0);
    @(posedge clk); #1 rst = 1'b1;
    // r0 writes AA to addr 0
    req = 2'b01; we = 2'b01; addr0 = 0; wdata0 = 8'hAA;
    w0 = wr_cnt;
    run_ack(a, n);
    req = 2'b00;
    chk("w_lat", n, 2);
    chk("w_ack", a, 2'b01);
    chk("w_pulses", wr_cnt - w0, 1);
    chk("w_addr", wr_addr, 0);
    @(posedge clk); #1;
    chk("w_ram0", ram[0], 8'hAA);
    // r1 reads addr 0
    req = 2'b10; we = 2'b00; addr1 = 0;
    run_ack(a, n);
    req = 2'b00;
    chk("r_lat", n, 3);
    chk("r_ack", a, 2'b10);
    chk("r_rdata", rdata, 8'hAA);
    // tie from reset: r0 writes FF to addr 1, r1 reads addr 1
    do_reset();
    req = 2'b11; we = 2'b01; addr0 = 1; wdata0 = 8'hFF; addr1 = 1;
    run_ack(a, n);
    chk("tie_first", a, 2'b01);
    chk("tie_lat", n, 2);
    req = 2'b10;
    run_ack(a, n);
    chk("tie_second", a, 2'b10);
    chk("tie_rdata", rdata, 8'hFF);
    chk("tie_lat2", n, 4);
    req = 2'b11; we = 2'b00;
    run_ack(a, n);
    chk("tie_third", a, 2'b01);
    req = 2'b00;
    // continuous contention alternates with one idle cycle between
    do_reset();
    we = 2'b11; addr0 = 0; addr1 = 0; wdata0 = 8'h01; wdata1 = 8'h02; req = 2'b11;
    prev = idle_cnt;
    for (int i = 0; i < 6; i++) begin
      run_ack(a, n);
      chk("alt_grant", a, (i % 2) ? 2'b10 : 2'b01);
      if (i > 0) chk("alt_gap", idle_cnt - prev, 1);
      prev = idle_cnt;
    end
    req = 2'b00;
    // reset during ACCESS of a write of 55 to addr 1
    do_reset();
    req = 2'b01; we = 2'b01; addr0 = 1; wdata0 = 8'h55;
    @(posedge clk); #1;
    chk("abort_inflight", mem_r_w, 1);
    rst = 1'b0;
    #1;
    chk("abort_wr", mem_r_w, 0);
    chk("abort_busy", busy, 0);
    chk("abort_addr", mem_address, 0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_ack", ack, 0);
    end
    req = 2'b00;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_ram1", ram[1], 8'hFF);
    chk("abort_noack", ack, 0);
    // payload change after latching is ignored
    req = 2'b01; we = 2'b01; addr0 = 0; wdata0 = 8'h11;
    @(posedge clk); #1;
    wdata0 = 8'h22;
    run_ack(a, n);
    req = 2'b00;
    chk("latch_ack", a, 2'b01);
    chk("latch_wdata", wr_data, 8'h11);
    @(posedge clk); #1;
    chk("latch_ram0", ram[0], 8'h11);
    chk("latch_rdata", rdata, 0);
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
